re_level3_sched: RTL and testbench
==================================

Name: re_level3_sched

Overview:
- Beat scheduler and sequencer for the level-3 4-point even-even butterfly stage of the shared forward/inverse DCT/IDCT datapath.
- Accepts one block command at a time: size 8/16/32, plus direction.
- Per block it:
  - meters N input beats from the level-2 source with a valid/ready handshake;
  - drives the stage's size-valid strobes and its direction select;
  - tracks the size-dependent stage latency;
  - emits output-valid, last and done flags aligned to the stage outputs.
- Sits between the level-2 output buffer and the transpose/level-4 consumer.

Parameters:
- CNT_W, 5, beat counter width; beats per block = N (8, 16, 32), i.e. one beat per column.
- LAT_8, 2, cycles from beat issue to stage output valid, size 8 (bypass path).
- LAT_L, 3, cycles from beat issue to stage output valid, sizes 16/32.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_start  in  1  block command valid
- i_size  in  2  0=8x8, 1=16x16, 2=32x32, 3=illegal
- i_inverse  in  1  1=inverse transform for this block
- o_cmd_rdy  out  1  command accepted when i_start&o_cmd_rdy
- i_in_vld  in  1  level-2 beat available
- o_in_rdy  out  1  beat consumed when i_in_vld&o_in_rdy
- o_dt_vld_8 / o_dt_vld_16 / o_dt_vld_32  out  1 each  stage strobes, one-hot or zero
- o_inverse  out  1  stage direction select
- o_out_vld  out  1  stage outputs valid this cycle
- o_out_last  out  1  final output beat of block
- o_done  out  1  one-cycle pulse, coincident with o_out_last
- o_err  out  1  one-cycle pulse, illegal size command rejected
- o_busy  out  1  block active or results in flight

Behaviour:
- Reset (synchronous, active-high): all outputs 0, FSM IDLE, counter 0, latency pipeline cleared. o_cmd_rdy=1 from the first cycle after rst deasserts. Reset mid-block discards all in-flight beats; no o_done is issued.
- States:
  - IDLE: o_cmd_rdy=1, o_in_rdy=0.
    - Command with size 0..2: latch size/inverse, beat_cnt=0, go to RUN.
    - Command with size 3: pulse o_err, stay IDLE.
  - RUN: o_in_rdy=1.
    - Each handshake drives the strobe for the latched size combinationally and increments beat_cnt.
    - o_cmd_rdy=1 only when beat_cnt==N-1 && i_in_vld (last beat transferring); this gives back-to-back blocks.
    - On the last beat:
      - new command accepted, previous size 16/32, new size 8: go to GAP;
      - new command accepted, any other size combination: stay in RUN with beat_cnt=0;
      - no command: go to IDLE.
    - Illegal size arriving on the last beat: o_err pulses, go to IDLE.
  - GAP: exactly 1 cycle, o_in_rdy=0, o_cmd_rdy=0, then go to RUN. This prevents a 16/32 result (LAT_L) and an 8 result (LAT_8) surfacing in the same cycle.
- Strobes are 0 on any cycle without a handshake. The stage holds its registers in that case.
- o_inverse is a register loaded with the latched inverse of the beat issued in the previous cycle. It holds otherwise. A direction change between back-to-back blocks therefore needs no bubble: the old block's last beat still sees the old value at the stage mux.
- Latency pipeline: 3-stage shift of {vld, last, is8} loaded at each handshake. o_out_vld/o_out_last/o_done are taken from stage 2 when is8, and from stage 3 otherwise.
- Outputs of a block appear in order, one per issued beat, including across a GAP.
- o_busy = (state!=IDLE) | any pipeline stage valid.
- i_size/i_inverse are sampled only at command acceptance; later changes are ignored.

Decomposition:
- Shared package (re_tq_pkg):
  - size encoding constants SZ_8/SZ_16/SZ_32;
  - LAT_8/LAT_L;
  - FSM state encoding (IDLE/RUN/GAP).
- One sub-module is natural: re_lat_pipe, the 3-stage {vld,last,is8} shift with size-selected tap.

Test Plan:
- 8x8 forward:
  - Stimulus: start size=0 inv=0, i_in_vld held high.
  - Expected: 8 consecutive o_dt_vld_8 pulses; o_out_vld cycles 2..9 after the first beat; o_out_last/o_done at cycle 9; o_busy low at cycle 10.
- 32x32 inverse with upstream stalls:
  - Stimulus: i_in_vld toggling 1,0,1,0.
  - Expected: exactly 32 o_dt_vld_32 pulses, none on stall cycles; o_inverse=1 from the cycle after the first beat; o_out_vld pattern equals the beat pattern delayed 3.
- Back-to-back 16 forward then 16 inverse:
  - Expected: no bubble, 32 contiguous strobes; o_inverse changes exactly one cycle after the first inverse beat; two o_done pulses, 16 cycles apart.
- 32 then 8:
  - Expected: exactly one GAP cycle with o_in_rdy=0 after beat 32; no cycle with coincident results from the two blocks; 40 o_out_vld total.
- Illegal size:
  - Stimulus: start size=3.
  - Expected: o_err single pulse, no strobes, o_busy stays 0.
- Reset mid-block:
  - Stimulus: rst for 1 cycle after beat 5 of a 16x16 block.
  - Expected: all outputs 0 next cycle; no o_done; a following 8x8 block completes normally.

Source files
------------

// File: rtl/re_level3_sched_pkg.sv
// Shared constants and types for the level-3 even-even butterfly beat scheduler.
package re_level3_sched_pkg;

    localparam int unsigned CNT_W  = 5;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned LAT_8  = 2;
    localparam int unsigned LAT_L  = 3;

    typedef enum logic [SIZE_W-1:0] {
        SZ_8   = 2'd0,
        SZ_16  = 2'd1,
        SZ_32  = 2'd2,
        SZ_BAD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    typedef struct packed {
        logic vld;
        logic last;
        logic is8;
    } lat_t;

    // Index of the final beat of a block (one beat per column).
    function automatic logic [CNT_W-1:0] last_beat_idx(input size_e sz);
        case (sz)
            SZ_8:    return CNT_W'(7);
            SZ_16:   return CNT_W'(15);
            default: return CNT_W'(31);
        endcase
    endfunction

endpackage

// File: rtl/re_level3_sched_if.sv
// Command, beat handshake and stage-control bundle of the level-3 scheduler.
interface re_level3_sched_if;
    import re_level3_sched_pkg::*;

    logic              i_start;
    logic [SIZE_W-1:0] i_size;
    logic              i_inverse;
    logic              o_cmd_rdy;
    logic              i_in_vld;
    logic              o_in_rdy;
    logic              o_dt_vld_8;
    logic              o_dt_vld_16;
    logic              o_dt_vld_32;
    logic              o_inverse;
    logic              o_out_vld;
    logic              o_out_last;
    logic              o_done;
    logic              o_err;
    logic              o_busy;

    modport master (
        output i_start, i_size, i_inverse, i_in_vld,
        input  o_cmd_rdy, o_in_rdy, o_dt_vld_8, o_dt_vld_16, o_dt_vld_32,
               o_inverse, o_out_vld, o_out_last, o_done, o_err, o_busy
    );

    modport slave (
        input  i_start, i_size, i_inverse, i_in_vld,
        output o_cmd_rdy, o_in_rdy, o_dt_vld_8, o_dt_vld_16, o_dt_vld_32,
               o_inverse, o_out_vld, o_out_last, o_done, o_err, o_busy
    );

endinterface

// File: rtl/re_level3_sched_lat_pipe.sv
// Stage-latency tracker: shift of {vld,last,is8} per issued beat, tapped at the
// size-8 bypass depth or the full 16/32 depth.
module re_lat_pipe
    import re_level3_sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_last,
    input  logic i_is8,
    output logic o_vld,
    output logic o_last,
    output logic o_busy
);

    lat_t [LAT_L:1] st_q;
    lat_t [LAT_L:1] st_d;
    logic [LAT_L:1] vld_vec;

    always_comb begin
        st_d = {st_q[LAT_L-1:1], lat_t'{vld: i_load, last: i_load & i_last, is8: i_load & i_is8}};
        // size-8 entries have already surfaced at their tap; retire them
        if (st_q[LAT_8].is8) begin
            st_d[LAT_8+1] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q <= '0;
        end else begin
            st_q <= st_d;
        end
    end

    for (genvar g = 1; g <= LAT_L; g++) begin : g_vld
        assign vld_vec[g] = st_q[g].vld;
    end

    assign o_busy = |vld_vec;
    assign o_vld  = (st_q[LAT_8].vld & st_q[LAT_8].is8) | (st_q[LAT_L].vld & ~st_q[LAT_L].is8);
    assign o_last = (st_q[LAT_8].last & st_q[LAT_8].is8) | (st_q[LAT_L].last & ~st_q[LAT_L].is8);

endmodule

// File: rtl/re_level3_sched.sv
// Beat scheduler for the level-3 4-point butterfly: meters N beats per block,
// drives size strobes/direction and emits latency-aligned valid/last/done.
module re_level3_sched
    import re_level3_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    re_level3_sched_if.slave bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    size_e            size_q, size_d;
    logic             inv_q, inv_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;

    logic  in_rdy, cmd_rdy, hs, cmd_acc, at_last;
    logic  pipe_vld, pipe_last, pipe_busy;
    size_e new_size;

    assign new_size = size_e'(bus.i_size);
    assign at_last  = (cnt_q == last_beat_idx(size_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            size_q <= SZ_8;
            inv_q  <= 1'b0;
            dir_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            size_q <= size_d;
            inv_q  <= inv_d;
            dir_q  <= dir_d;
            err_q  <= err_d;
        end
    end

    // Next state, beat counter and per-block command latch
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        inv_d   = inv_q;
        err_d   = 1'b0;
        dir_d   = hs ? inv_q : dir_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_acc) begin
                    if (new_size == SZ_BAD) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        size_d  = new_size;
                        inv_d   = bus.i_inverse;
                    end
                end
            end
            ST_RUN: begin
                if (hs) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (at_last) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                        if (cmd_acc) begin
                            if (new_size == SZ_BAD) begin
                                err_d = 1'b1;
                            end else begin
                                size_d  = new_size;
                                inv_d   = bus.i_inverse;
                                // 16/32 -> 8 would land both results on one cycle
                                state_d = (size_q != SZ_8 && new_size == SZ_8) ? ST_GAP : ST_RUN;
                            end
                        end
                    end
                end
            end
            ST_GAP:  state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    // Ready, handshake and stage strobe decode
    always_comb begin
        in_rdy  = 1'b0;
        cmd_rdy = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: cmd_rdy = 1'b1;
                ST_RUN: begin
                    in_rdy  = 1'b1;
                    cmd_rdy = at_last & bus.i_in_vld;
                end
                default: ;
            endcase
        end
        hs              = in_rdy & bus.i_in_vld;
        cmd_acc         = bus.i_start & cmd_rdy;
        bus.o_in_rdy    = in_rdy;
        bus.o_cmd_rdy   = cmd_rdy;
        bus.o_dt_vld_8  = hs & (size_q == SZ_8);
        bus.o_dt_vld_16 = hs & (size_q == SZ_16);
        bus.o_dt_vld_32 = hs & (size_q == SZ_32);
    end

    re_lat_pipe u_lat_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_load (hs),
        .i_last (at_last),
        .i_is8  (size_q == SZ_8),
        .o_vld  (pipe_vld),
        .o_last (pipe_last),
        .o_busy (pipe_busy)
    );

    assign bus.o_inverse  = dir_q;
    assign bus.o_err      = err_q;
    assign bus.o_out_vld  = pipe_vld;
    assign bus.o_out_last = pipe_last;
    assign bus.o_done     = pipe_last;
    assign bus.o_busy     = (state_q != ST_IDLE) | pipe_busy;

endmodule

// File: tb/tb_re_level3_sched.sv
// Self-checking bench for re_level3_sched: block table plus directed sequences,
// with a scoreboard of expected output beats timed from each observed handshake.
module tb_re_level3_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    re_level3_sched_if bus ();

    re_level3_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   due;
        logic last;
    } exp_t;

    typedef struct {
        logic [1:0] size;
        logic       inv;
    } blk_t;

    typedef struct {
        logic [1:0] size;
        logic       inv;
        logic       stall;
        int         n_stb;
        int         n_out;
        int         n_done;
        int         n_err;
        int         busy_dly;
    } vec_t;

    exp_t exp_q[$];
    blk_t blk_q[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_stb = 0, n_out = 0, n_done = 0, n_errp = 0;
    int   first_prev = 0, first_cur = 0, done_prev = 0, done_cur = 0;
    int   beat_idx = 0;
    logic exp_dir  = 1'b0;
    logic err_pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [2:0] stb_of(input logic [1:0] s);
        logic [2:0] one;
        one = 3'b001;
        return (s == 2'd3) ? 3'b000 : (one << s);
    endfunction

    // Scoreboard monitor: checks strobes, direction, error and output beats every cycle
    always @(negedge clk) begin
        logic       hs;
        logic [2:0] stb_exp;
        logic       ev, el;
        blk_t       b;
        exp_t       e;
        int         n;
        if (rst) begin
            exp_q.delete();
            blk_q.delete();
            exp_dir  = 1'b0;
            err_pend = 1'b0;
            beat_idx = 0;
        end else begin
            hs      = bus.i_in_vld & bus.o_in_rdy;
            stb_exp = 3'b000;
            if (hs) begin
                check("beat_owner", 32'(blk_q.size() > 0), 32'(1));
                if (blk_q.size() > 0) stb_exp = stb_of(blk_q[0].size);
            end
            check("strobes", 32'({bus.o_dt_vld_32, bus.o_dt_vld_16, bus.o_dt_vld_8}), 32'(stb_exp));
            check("inverse", 32'(bus.o_inverse), 32'(exp_dir));
            check("err", 32'(bus.o_err), 32'(err_pend));
            ev = 1'b0;
            el = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                ev = 1'b1;
                el = exp_q[0].last;
                void'(exp_q.pop_front());
            end
            check("out_vld_last_done", 32'({bus.o_out_vld, bus.o_out_last, bus.o_done}), 32'({ev, el, el}));

            if (hs && blk_q.size() > 0) begin
                b = blk_q[0];
                n = 8 << b.size;
                if (beat_idx == 0) begin
                    first_prev = first_cur;
                    first_cur  = cyc;
                end
                e.due  = cyc + ((b.size == 2'd0) ? 2 : 3);
                e.last = (beat_idx == n - 1);
                exp_q.push_back(e);
                exp_dir = b.inv;
                beat_idx++;
                if (beat_idx == n) begin
                    beat_idx = 0;
                    void'(blk_q.pop_front());
                end
            end
            err_pend = 1'b0;
            if (bus.i_start && bus.o_cmd_rdy) begin
                if (bus.i_size == 2'd3) begin
                    err_pend = 1'b1;
                end else begin
                    b.size = bus.i_size;
                    b.inv  = bus.i_inverse;
                    blk_q.push_back(b);
                end
            end
            if (bus.o_dt_vld_8 || bus.o_dt_vld_16 || bus.o_dt_vld_32) n_stb++;
            if (bus.o_out_vld) n_out++;
            if (bus.o_err) n_errp++;
            if (bus.o_done) begin
                n_done++;
                done_prev = done_cur;
                done_cur  = cyc;
            end
        end
    end

    task automatic wait_cmd_rdy();
        int k = 0;
        @(negedge clk);
        while (!bus.o_cmd_rdy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("cmd_rdy", 32'(bus.o_cmd_rdy), 32'(1));
    endtask

    task automatic run_block(input logic [1:0] sz, input logic inv, input logic stall, output int dly);
        int nb, k, n;
        n   = (sz == 2'd3) ? 0 : (8 << sz);
        dly = -1;
        @(posedge clk); #1;
        bus.i_start   = 1'b1;
        bus.i_size    = sz;
        bus.i_inverse = inv;
        wait_cmd_rdy();
        @(posedge clk); #1;
        bus.i_start   = 1'b0;
        bus.i_size    = 2'($urandom);
        bus.i_inverse = 1'($urandom);
        if (n == 0) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check("err_busy", 32'(bus.o_busy), 32'(0));
                check("err_in_rdy", 32'(bus.o_in_rdy), 32'(0));
            end
        end else begin
            nb = 0;
            k  = 0;
            while (nb < n && k < 200) begin
                bus.i_in_vld = stall ? (k % 2 == 0) : 1'b1;
                @(negedge clk);
                if (bus.i_in_vld && bus.o_in_rdy) nb++;
                @(posedge clk); #1;
                k++;
            end
            bus.i_in_vld = 1'b0;
            check("beats_taken", 32'(nb), 32'(n));
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (bus.o_busy && k < 50);
            check("busy_drop", 32'(bus.o_busy), 32'(0));
            dly = cyc - first_cur;
        end
    endtask

    task automatic run_pair(input logic [1:0] s1, input logic i1, input logic [1:0] s2, input logic i2,
                            output int first_low);
        int   k;
        logic acc;
        @(posedge clk); #1;
        bus.i_start   = 1'b1;
        bus.i_size    = s1;
        bus.i_inverse = i1;
        wait_cmd_rdy();
        @(posedge clk); #1;
        bus.i_size    = s2;
        bus.i_inverse = i2;
        bus.i_in_vld  = 1'b1;
        acc       = 1'b0;
        k         = 0;
        first_low = -1;
        while (k < 200) begin
            @(negedge clk);
            if (bus.i_start && bus.o_cmd_rdy) acc = 1'b1;
            if (!bus.o_in_rdy && first_low < 0) first_low = cyc;
            if (!bus.o_busy) break;
            @(posedge clk); #1;
            if (acc) bus.i_start = 1'b0;
            k++;
        end
        bus.i_in_vld = 1'b0;
        bus.i_start  = 1'b0;
        check("pair_cmd2_accepted", 32'(acc), 32'(1));
        check("pair_drain", 32'(bus.o_busy), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        int   s0, o0, d0, e0, dly, low;

        vecs[0] = '{size: 2'd0, inv: 1'b0, stall: 1'b0, n_stb: 8,  n_out: 8,  n_done: 1, n_err: 0, busy_dly: 10};
        vecs[1] = '{size: 2'd2, inv: 1'b1, stall: 1'b1, n_stb: 32, n_out: 32, n_done: 1, n_err: 0, busy_dly: 66};
        vecs[2] = '{size: 2'd1, inv: 1'b0, stall: 1'b0, n_stb: 16, n_out: 16, n_done: 1, n_err: 0, busy_dly: 19};
        vecs[3] = '{size: 2'd3, inv: 1'b1, stall: 1'b0, n_stb: 0,  n_out: 0,  n_done: 0, n_err: 1, busy_dly: -1};
        vecs[4] = '{size: 2'd1, inv: 1'b1, stall: 1'b1, n_stb: 16, n_out: 16, n_done: 1, n_err: 0, busy_dly: 34};
        vecs[5] = '{size: 2'd0, inv: 1'b1, stall: 1'b1, n_stb: 8,  n_out: 8,  n_done: 1, n_err: 0, busy_dly: 17};

        bus.i_start   = 1'b0;
        bus.i_size    = 2'd0;
        bus.i_inverse = 1'b0;
        bus.i_in_vld  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_rdy", 32'(bus.o_cmd_rdy), 32'(1));
        check("rst_in_rdy", 32'(bus.o_in_rdy), 32'(0));
        check("rst_busy", 32'(bus.o_busy), 32'(0));

        for (int r = 0; r < 6; r++) begin
            s0 = n_stb; o0 = n_out; d0 = n_done; e0 = n_errp;
            run_block(vecs[r].size, vecs[r].inv, vecs[r].stall, dly);
            check($sformatf("row%0d_strobes", r), 32'(n_stb - s0), 32'(vecs[r].n_stb));
            check($sformatf("row%0d_outs", r), 32'(n_out - o0), 32'(vecs[r].n_out));
            check($sformatf("row%0d_dones", r), 32'(n_done - d0), 32'(vecs[r].n_done));
            check($sformatf("row%0d_errs", r), 32'(n_errp - e0), 32'(vecs[r].n_err));
            if (vecs[r].busy_dly >= 0)
                check($sformatf("row%0d_busy_low_delay", r), 32'(dly), 32'(vecs[r].busy_dly));
        end

        // 16 forward then 16 inverse, back to back
        s0 = n_stb; o0 = n_out; d0 = n_done;
        run_pair(2'd1, 1'b0, 2'd1, 1'b1, low);
        check("b2b_first_beat_spacing", 32'(first_cur - first_prev), 32'(16));
        check("b2b_done_spacing", 32'(done_cur - done_prev), 32'(16));
        check("b2b_strobes", 32'(n_stb - s0), 32'(32));
        check("b2b_dones", 32'(n_done - d0), 32'(2));

        // 32 then 8 needs exactly one gap cycle
        o0 = n_out; d0 = n_done;
        run_pair(2'd2, 1'b0, 2'd0, 1'b0, low);
        check("gap_first_beat_spacing", 32'(first_cur - first_prev), 32'(33));
        check("gap_in_rdy_low_cycle", 32'(low - first_prev), 32'(32));
        check("gap_outs", 32'(n_out - o0), 32'(40));
        check("gap_dones", 32'(n_done - d0), 32'(2));

        // 8 then 32: no gap needed
        o0 = n_out;
        run_pair(2'd0, 1'b1, 2'd2, 1'b0, low);
        check("nogap_first_beat_spacing", 32'(first_cur - first_prev), 32'(8));
        check("nogap_outs", 32'(n_out - o0), 32'(40));

        // illegal size arriving on the last beat of a 16 block
        o0 = n_out; d0 = n_done; e0 = n_errp;
        run_pair(2'd1, 1'b1, 2'd3, 1'b0, low);
        check("lastbeat_err", 32'(n_errp - e0), 32'(1));
        check("lastbeat_err_outs", 32'(n_out - o0), 32'(16));
        check("lastbeat_err_dones", 32'(n_done - d0), 32'(1));

        // reset after beat 5 of a 16x16 block
        d0 = n_done;
        begin
            int nb, k;
            @(posedge clk); #1;
            bus.i_start   = 1'b1;
            bus.i_size    = 2'd1;
            bus.i_inverse = 1'b1;
            wait_cmd_rdy();
            @(posedge clk); #1;
            bus.i_start  = 1'b0;
            bus.i_in_vld = 1'b1;
            nb = 0;
            k  = 0;
            while (nb < 5 && k < 50) begin
                @(negedge clk);
                if (bus.i_in_vld && bus.o_in_rdy) nb++;
                @(posedge clk); #1;
                k++;
            end
            check("rst_mid_beats", 32'(nb), 32'(5));
            rst          = 1'b1;
            bus.i_in_vld = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            check("rst_mid_busy", 32'(bus.o_busy), 32'(0));
            check("rst_mid_in_rdy", 32'(bus.o_in_rdy), 32'(0));
            check("rst_mid_out_vld", 32'(bus.o_out_vld), 32'(0));
            check("rst_mid_inverse", 32'(bus.o_inverse), 32'(0));
            check("rst_mid_cmd_rdy", 32'(bus.o_cmd_rdy), 32'(1));
            repeat (5) @(negedge clk);
            check("rst_mid_no_done", 32'(n_done - d0), 32'(0));
        end
        o0 = n_out; d0 = n_done;
        run_block(2'd0, 1'b0, 1'b0, dly);
        check("post_rst_outs", 32'(n_out - o0), 32'(8));
        check("post_rst_dones", 32'(n_done - d0), 32'(1));
        check("post_rst_busy_delay", 32'(dly), 32'(10));

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
